imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Word stream in, byte-wide instruction memory write port out.
interface imem_loader_if #(
   parameter int ADDR_W = 8
) ();
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_word;
   logic              in_last;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_wren;

   modport master (
      output in_valid, in_word, in_last,
      input  in_ready, mem_addr, mem_data, mem_wren
   );

   modport slave (
      input  in_valid, in_word, in_last,
      output in_ready, mem_addr, mem_data, mem_wren
   );
endinterface

// File: rtl/imem_loader.sv
// Splits 32-bit words into big-endian bytes and writes
// them one per cycle into the instruction memory.
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            start,
   imem_loader_if.slave    bus,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [ADDR_W:0] byte_count
);

   typedef enum logic [2:0] {
      IDLE, LOAD, WRITE, DONE, ERR
   } state_t;

   localparam logic [ADDR_W:0] BASE = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   state_t          state_q, state_d;
   logic [ADDR_W:0] ptr_q, ptr_d;
   logic [31:0]     word_q, word_d;
   logic            last_q, last_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      byte_sel;
   logic            full;
   logic            wr;

   // ptr carries one extra bit so "memory full" is ptr == 2^ADDR_W
   assign full = ptr_q[ADDR_W];
   assign wr   = (state_q == WRITE);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         ptr_q   <= BASE;
         word_q  <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         word_q  <= word_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      word_d  = word_q;
      last_d  = last_q;
      idx_d   = idx_q;
      unique case (state_q)
         LOAD: begin
            if (full) begin
               state_d = ERR;
            end else if (bus.in_valid) begin
               word_d  = bus.in_word;
               last_d  = bus.in_last;
               idx_d   = 2'd0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            ptr_d = ptr_q + ONE;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = last_q ? DONE : LOAD;
            end
         end
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LOAD;
               ptr_d   = BASE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_sel = word_q[31:24];
      unique case (idx_q)
         2'd0: byte_sel = word_q[31:24];
         2'd1: byte_sel = word_q[23:16];
         2'd2: byte_sel = word_q[15:8];
         2'd3: byte_sel = word_q[7:0];
      endcase
   end

   assign bus.in_ready = (state_q == LOAD) && !full;
   assign bus.mem_wren = wr;
   assign bus.mem_addr = wr ? ptr_q[ADDR_W-1:0] : '0;
   assign bus.mem_data = wr ? byte_sel : '0;

   assign busy       = (state_q == LOAD) || wr;
   assign done       = (state_q == DONE);
   assign error      = (state_q == ERR);
   assign byte_count = ptr_q - BASE;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random programs vs a
// byte-image reference model, plus reset/full/base cases.
module tb_imem_loader;

   localparam int AW  = 8;
   localparam int CAP = 1 << AW;
   localparam int B1  = 16;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic start = 1'b0;
   logic start1 = 1'b0;
   logic busy, done, error;
   logic busy1, done1, error1;
   logic [AW:0] bc, bc1;

   imem_loader_if #(.ADDR_W(AW)) b0 ();
   imem_loader_if #(.ADDR_W(AW)) b1 ();

   imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .start(start), .bus(b0),
      .busy(busy), .done(done), .error(error),
      .byte_count(bc)
   );

   imem_loader #(.ADDR_W(AW), .BASE_ADDR(B1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .start(start1), .bus(b1),
      .busy(busy1), .done(done1), .error(error1),
      .byte_count(bc1)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   wr_t q0[$];
   wr_t q1[$];
   wr_t e0, e1;
   int  checks = 0;
   int  fails = 0;
   int  mptr;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: a word at byte address p lands as MSB-first bytes.
   task automatic push_word(input int p, input logic [31:0] w,
                            input int n);
      for (int k = 0; k < n; k++)
         q0.push_back(wr_t'{a: AW'(p + k),
                            d: 8'(w >> (8 * (3 - k)))});
   endtask

   always @(negedge CLK) begin
      if (b0.mem_wren === 1'b1) begin
         if (q0.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected write0: addr %0h data %0h required none",
                     b0.mem_addr, b0.mem_data);
         end else begin
            e0 = q0.pop_front();
            chk("wr0 addr", 32'(b0.mem_addr), 32'(e0.a));
            chk("wr0 data", 32'(b0.mem_data), 32'(e0.d));
         end
      end
      if (b1.mem_wren === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected write1: addr %0h data %0h required none",
                     b1.mem_addr, b1.mem_data);
         end else begin
            e1 = q1.pop_front();
            chk("wr1 addr", 32'(b1.mem_addr), 32'(e1.a));
            chk("wr1 data", 32'(b1.mem_data), 32'(e1.d));
         end
      end
   end

   task automatic do_start();
      @(negedge CLK);
      start = 1'b1;
      mptr = 0;
      @(negedge CLK);
      start = 1'b0;
      chk("ready after start", 32'(b0.in_ready), 32'd1);
      chk("bc after start", 32'(bc), 32'd0);
   endtask

   // Called at a negedge; offers a word and follows its burst.
   task automatic send(input logic [31:0] w, input logic last,
                       input bit pulse);
      int n = 0;
      b0.in_word  = w;
      b0.in_last  = last;
      b0.in_valid = 1'b1;
      while (b0.in_ready !== 1'b1 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) begin
         checks++;
         fails++;
         $display("FAIL handshake timeout: in_ready %b required 1",
                  b0.in_ready);
         b0.in_valid = 1'b0;
         return;
      end
      push_word(mptr, w, 4);
      mptr += 4;
      @(posedge CLK);
      #1;
      b0.in_valid = 1'b0;
      b0.in_word  = $urandom;
      b0.in_last  = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("burst wren", 32'(b0.mem_wren), 32'd1);
         chk("burst ready", 32'(b0.in_ready), 32'd0);
         start = (pulse && k == 1);
      end
      @(negedge CLK);
      start = 1'b0;
      chk("wren drop", 32'(b0.mem_wren), 32'd0);
      if (last) chk("done", 32'(done), 32'd1);
      else chk("ready again", 32'(b0.in_ready), 32'(mptr < CAP));
      chk("byte_count", 32'(bc), 32'(mptr));
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) @(negedge CLK);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " ready"}, 32'(b0.in_ready), 32'd0);
      chk({nm, " wren"}, 32'(b0.mem_wren), 32'd0);
      chk({nm, " addr"}, 32'(b0.mem_addr), 32'd0);
      chk({nm, " data"}, 32'(b0.mem_data), 32'd0);
      chk({nm, " flags"}, {29'd0, busy, done, error}, 32'd0);
      chk({nm, " bc"}, 32'(bc), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [31:0] prog [4];
   int nw;

   initial begin
      prog[0] = 32'h20090004;
      prog[1] = 32'h200B0005;
      prog[2] = 32'h012B5020;
      prog[3] = 32'h8D490004;
      b0.in_valid = 1'b0;
      b0.in_word  = '0;
      b0.in_last  = 1'b0;
      b1.in_valid = 1'b0;
      b1.in_word  = '0;
      b1.in_last  = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk_zero("reset");
      chk("reset1 addr", 32'(b1.mem_addr), 32'd0);
      chk("reset1 bc", 32'(bc1), 32'd0);

      b0.in_valid = 1'b1;
      repeat (6) begin
         @(negedge CLK);
         chk("idle ready", 32'(b0.in_ready), 32'd0);
         chk("idle busy", 32'(busy), 32'd0);
      end
      b0.in_valid = 1'b0;

      do_start();
      send(32'h20090004, 1'b1, 1'b0);

      do_start();
      for (int i = 0; i < 4; i++) begin
         send(prog[i], 1'(i == 3), i == 1);
         gap();
      end

      for (int s = 0; s < 3; s++) begin
         do_start();
         nw = $urandom_range(1, 10);
         for (int i = 0; i < nw; i++) begin
            send($urandom, 1'(i == nw - 1), 1'($urandom));
            gap();
         end
      end

      do_start();
      b0.in_word  = 32'hCAFEF00D;
      b0.in_last  = 1'b1;
      b0.in_valid = 1'b1;
      push_word(0, 32'hCAFEF00D, 2);
      @(posedge CLK);
      #1;
      b0.in_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("pre-reset wren", 32'(b0.mem_wren), 32'd1);
      RST_N = 1'b0;
      @(negedge CLK);
      chk_zero("midreset");
      RST_N = 1'b1;
      do_start();
      send(32'h13579BDF, 1'b1, 1'b0);

      do_start();
      for (int i = 0; i < CAP / 4; i++) begin
         send($urandom, 1'b0, 1'b0);
         if (i % 8 == 0) gap();
      end
      b0.in_valid = 1'b1;
      b0.in_last  = 1'b1;
      repeat (8) begin
         @(negedge CLK);
         chk("full ready", 32'(b0.in_ready), 32'd0);
         chk("full error", 32'(error), 32'd1);
         chk("full bc", 32'(bc), 32'(CAP));
      end
      b0.in_valid = 1'b0;
      do_start();
      send(32'h0BADBEEF, 1'b1, 1'b0);

      @(negedge CLK);
      start1 = 1'b1;
      @(negedge CLK);
      start1 = 1'b0;
      chk("ready1", 32'(b1.in_ready), 32'd1);
      b1.in_word  = 32'hA1B2C3D4;
      b1.in_last  = 1'b1;
      b1.in_valid = 1'b1;
      for (int k = 0; k < 4; k++)
         q1.push_back(wr_t'{a: AW'(B1 + k),
                            d: 8'(32'hA1B2C3D4 >> (8 * (3 - k)))});
      @(posedge CLK);
      #1;
      b1.in_valid = 1'b0;
      repeat (5) @(negedge CLK);
      chk("done1", 32'(done1), 32'd1);
      chk("bc1", 32'(bc1), 32'd4);

      repeat (3) @(negedge CLK);
      chk("q0 drained", 32'(q0.size()), 32'd0);
      chk("q1 drained", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
